amul_err_monitor: RTL and testbench
===================================

Name: amul_err_monitor

Overview:
Downstream checker for the 8x8 approximate multiplier stages. It consumes each operand pair together with the approximate 16-bit product and recomputes the exact product. Over a window of 2^WIN_LOG2 samples it accumulates error statistics and presents them through a valid/ready report interface. Used in characterisation benches and on-chip self-test to quantify accuracy per approximate configuration.

Parameters:
WIN_LOG2, 8, log2 of samples per window; legal range 1..12
PIPE_EXACT, 1, 1 = exact product registered in stage 1; 0 = exact product combinational into stage 2 (latency unchanged)

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  pulse; begins a window when idle
clear  input  1  synchronous abort; return to IDLE, zero accumulators
in_vld  input  1  sample valid
in_rdy  output  1  sample ready
in_a  input  8  operand A (unsigned)
in_b  input  8  operand B (unsigned)
in_p  input  16  approximate product under test
busy  output  1  high in any state other than IDLE
st_vld  output  1  statistics valid
st_rdy  input  1  statistics accepted
st_cnt  output  WIN_LOG2+1  samples in window
st_err_cnt  output  WIN_LOG2+1  samples with nonzero error
st_sum_ed  output  16+WIN_LOG2  sum of |exact - approx|
st_sum_sed  output  17+WIN_LOG2  two's-complement sum of (exact - approx)
st_max_ed  output  16  maximum |exact - approx|

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0, including in_rdy, st_vld and busy; accumulators, counters and pipeline valids 0.
- FSM states: IDLE, ACCUM, DRAIN, REPORT.
- IDLE: start=1 and clear=0 -> ACCUM; accumulators and counters zeroed on this transition.
- ACCUM: in_rdy = 1 while the accepted-sample count < 2^WIN_LOG2. A sample is accepted when in_vld & in_rdy. On the edge that accepts sample number 2^WIN_LOG2, go to DRAIN; in_rdy drops in the following cycle.
- DRAIN: wait until both pipeline stage valids are 0 (at most 2 cycles), then go to REPORT.
- REPORT: st_vld=1 with all st_* outputs stable. st_vld & st_rdy -> IDLE with st_vld=0 next cycle. The st_* values stay at their last contents until the next window starts.
- start outside IDLE is ignored.
- clear in any state -> IDLE next cycle, accumulators zeroed, any report dropped. clear beats start when both are asserted in the same cycle.
- Pipeline:
  - Stage 1 registers in_a, in_b, in_p and a valid bit; with PIPE_EXACT=1 it also registers exact = in_a*in_b (16 bit, unsigned).
  - Stage 2 computes diff = exact - in_p as 17-bit signed and ed = |diff| as 16 bit (cannot overflow), and updates the accumulators.
  - An accepted sample is reflected in the accumulators 2 cycles after acceptance.
  - The pipeline is never stalled, since input acceptance alone controls flow.
- Accumulator update per stage-2 valid:
  - st_cnt += 1
  - st_err_cnt += (ed != 0)
  - st_sum_ed += ed
  - st_sum_sed += sign-extended diff
  - st_max_ed = max(st_max_ed, ed)
- Widths are sized so no accumulator can overflow within one window (worst case 2^WIN_LOG2 * 65535). No saturation logic is needed.
- Samples presented while in_rdy=0 are neither consumed nor counted.

Test Plan:
1. WIN_LOG2=2, samples (3,5,p=15),(10,10,100),(0,77,0),(255,1,255) -> st_cnt=4, st_err_cnt=0, st_sum_ed=0, st_sum_sed=0, st_max_ed=0; st_vld rises no earlier than 2 cycles after the 4th accept.
2. WIN_LOG2=2, samples (255,255,p=65535),(16,16,256),(7,9,60),(0,200,0) -> st_err_cnt=2, st_sum_ed=513, st_sum_sed=-507, st_max_ed=510.
3. Case 2 with in_vld toggled 1/0 every cycle and st_rdy held low 5 cycles in REPORT -> identical stats; st_vld stays high and stable; in_rdy=0 during DRAIN and REPORT; 5th presented sample is not consumed.
4. clear asserted after 2 accepts -> IDLE next cycle, busy=0, st_vld never rises; new start plus case 1 samples -> case 1 results, with no residue from the aborted window.
5. rst_n driven low mid-REPORT, asynchronous to clk -> st_vld, busy, in_rdy and all st_* read 0 immediately, before the next clock edge.
6. start pulsed during ACCUM -> ignored, count continues. start and clear asserted together in IDLE -> remain IDLE, busy=0.

Source files
------------

// File: rtl/amul_err_monitor.sv
// amul_err_monitor
// Accuracy checker for the 8x8 approximate multiplier stages. Each sample
// carries both operands and the approximate product. The monitor recomputes
// the exact product, and over a window of 2^WIN_LOG2 samples it accumulates
// the error count, the absolute and signed error sums, and the maximum
// absolute error. The totals are then offered on a valid/ready report port.
module amul_err_monitor #(
    parameter int WIN_LOG2   = 8,
    parameter bit PIPE_EXACT = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  clear,
    input  logic                  in_vld,
    output logic                  in_rdy,
    input  logic [7:0]            in_a,
    input  logic [7:0]            in_b,
    input  logic [15:0]           in_p,
    output logic                  busy,
    output logic                  st_vld,
    input  logic                  st_rdy,
    output logic [WIN_LOG2:0]     st_cnt,
    output logic [WIN_LOG2:0]     st_err_cnt,
    output logic [15+WIN_LOG2:0]  st_sum_ed,
    output logic [16+WIN_LOG2:0]  st_sum_sed,
    output logic [15:0]           st_max_ed
);

    localparam int CNT_W = WIN_LOG2 + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'((1 << WIN_LOG2) - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DRAIN,
        REPORT
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] acc_cnt;   // samples accepted so far in this window
    logic             accept;

    // Stage 1 registers
    logic             s1_vld;
    logic [7:0]       s1_a;
    logic [7:0]       s1_b;
    logic [15:0]      s1_p;
    logic [15:0]      s1_exact;

    // Stage 2 combinational error terms
    logic [15:0]      prod_s2;
    logic [15:0]      exact_s2;
    logic [16:0]      diff;
    logic [15:0]      ed;

    assign accept = in_vld & in_rdy;

    // Control FSM. The handshake and status outputs are registered alongside
    // the state so that they never glitch. clear has priority over every
    // transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            in_rdy  <= 1'b0;
            busy    <= 1'b0;
            st_vld  <= 1'b0;
            acc_cnt <= '0;
        end else if (clear) begin
            state   <= IDLE;
            in_rdy  <= 1'b0;
            busy    <= 1'b0;
            st_vld  <= 1'b0;
            acc_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= ACCUM;
                        in_rdy  <= 1'b1;
                        busy    <= 1'b1;
                        acc_cnt <= '0;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        acc_cnt <= acc_cnt + CNT_W'(1);
                        if (acc_cnt == LAST_IDX) begin
                            state  <= DRAIN;
                            in_rdy <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    // The last sample is folded in on the edge after it leaves stage 1.
                    if (!s1_vld) begin
                        state  <= REPORT;
                        st_vld <= 1'b1;
                    end
                end
                REPORT: begin
                    if (st_rdy) begin
                        state  <= IDLE;
                        st_vld <= 1'b0;
                        busy   <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Stage 1: capture the accepted sample. With PIPE_EXACT set, the exact
    // product is also captured here.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples values from before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld   <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_p     <= '0;
            s1_exact <= '0;
        end else begin
            s1_vld <= accept & ~clear;
            if (accept) begin
                s1_a     <= in_a;
                s1_b     <= in_b;
                s1_p     <= in_p;
                s1_exact <= {8'd0, in_a} * {8'd0, in_b};
            end
        end
    end

    // Stage 2: the signed and absolute error of the sample held in stage 1.
    // NOTE: every signal here is assigned on every pass, so no latch is inferred.
    always_comb begin
        prod_s2  = {8'd0, s1_a} * {8'd0, s1_b};
        exact_s2 = PIPE_EXACT ? s1_exact : prod_s2;
        diff     = {1'b0, exact_s2} - {1'b0, s1_p};
        ed       = diff[16] ? 16'(-diff) : diff[15:0];
    end

    // Accumulators. These are zeroed on clear and at window start. They are
    // updated once per valid stage-2 sample and otherwise hold their value,
    // so the last report stays readable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_cnt     <= '0;
            st_err_cnt <= '0;
            st_sum_ed  <= '0;
            st_sum_sed <= '0;
            st_max_ed  <= '0;
        end else if (clear || (state == IDLE && start)) begin
            st_cnt     <= '0;
            st_err_cnt <= '0;
            st_sum_ed  <= '0;
            st_sum_sed <= '0;
            st_max_ed  <= '0;
        end else if (s1_vld) begin
            st_cnt     <= st_cnt + CNT_W'(1);
            st_err_cnt <= st_err_cnt + CNT_W'(ed != 16'd0);
            st_sum_ed  <= st_sum_ed + {{WIN_LOG2{1'b0}}, ed};
            st_sum_sed <= st_sum_sed + {{WIN_LOG2{diff[16]}}, diff};
            if (ed > st_max_ed) begin
                st_max_ed <= ed;
            end
        end
    end

endmodule

// File: tb/tb_amul_err_monitor.sv
// Directed testbench for amul_err_monitor with a four-sample window.
module tb_amul_err_monitor;

    localparam int W = 2;
    // -507 as a 19-bit two's-complement pattern
    localparam logic [18:0] SED_NEG507 = 19'h7FE05;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          clear = 1'b0;
    logic          in_vld = 1'b0;
    logic          in_rdy;
    logic [7:0]    in_a = '0;
    logic [7:0]    in_b = '0;
    logic [15:0]   in_p = '0;
    logic          busy;
    logic          st_vld;
    logic          st_rdy = 1'b0;
    logic [W:0]    st_cnt;
    logic [W:0]    st_err_cnt;
    logic [15+W:0] st_sum_ed;
    logic [16+W:0] st_sum_sed;
    logic [15:0]   st_max_ed;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  c1_a [4] = '{8'd3, 8'd10, 8'd0, 8'd255};
    logic [7:0]  c1_b [4] = '{8'd5, 8'd10, 8'd77, 8'd1};
    logic [15:0] c1_p [4] = '{16'd15, 16'd100, 16'd0, 16'd255};
    logic [7:0]  c2_a [4] = '{8'd255, 8'd16, 8'd7, 8'd0};
    logic [7:0]  c2_b [4] = '{8'd255, 8'd16, 8'd9, 8'd200};
    logic [15:0] c2_p [4] = '{16'd65535, 16'd256, 16'd60, 16'd0};

    amul_err_monitor #(.WIN_LOG2(W), .PIPE_EXACT(1'b1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .clear      (clear),
        .in_vld     (in_vld),
        .in_rdy     (in_rdy),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_p       (in_p),
        .busy       (busy),
        .st_vld     (st_vld),
        .st_rdy     (st_rdy),
        .st_cnt     (st_cnt),
        .st_err_cnt (st_err_cnt),
        .st_sum_ed  (st_sum_ed),
        .st_sum_sed (st_sum_sed),
        .st_max_ed  (st_max_ed)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_stats(input string tag, input int cnt, input int err,
                               input int sum_ed, input logic [18:0] sed, input int mx);
        check({tag, "_cnt"},     32'(st_cnt),     32'(cnt));
        check({tag, "_err_cnt"}, 32'(st_err_cnt), 32'(err));
        check({tag, "_sum_ed"},  32'(st_sum_ed),  32'(sum_ed));
        check({tag, "_sum_sed"}, 32'(st_sum_sed), 32'(sed));
        check({tag, "_max_ed"},  32'(st_max_ed),  32'(mx));
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Present one sample and hold it until it is accepted (bounded wait).
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [15:0] p);
        int waited = 0;
        in_a = a;
        in_b = b;
        in_p = p;
        in_vld = 1'b1;
        while (!in_rdy && waited < 20) begin
            tick();
            waited++;
        end
        if (!in_rdy) check("accept_timeout", 32'(in_rdy), 32'd1);
        else tick();
        in_vld = 1'b0;
    endtask

    task automatic wait_report(input string tag);
        int n = 0;
        while (!st_vld && n < 10) begin
            tick();
            n++;
        end
        check(tag, 32'(st_vld), 32'd1);
    endtask

    task automatic finish_report(input string tag);
        st_rdy = 1'b1;
        tick();
        st_rdy = 1'b0;
        check({tag, "_vld_low"},  32'(st_vld), 32'd0);
        check({tag, "_busy_low"}, 32'(busy),   32'd0);
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check("rst_in_rdy", 32'(in_rdy), 32'd0);
        check("rst_busy",   32'(busy),   32'd0);
        check("rst_st_vld", 32'(st_vld), 32'd0);
        check_stats("rst", 0, 0, 0, 19'd0, 0);
        #3 rst_n = 1'b1;
        tick();

        // 1: exact samples, zero error, report latency
        pulse_start();
        check("t1_busy",   32'(busy),   32'd1);
        check("t1_in_rdy", 32'(in_rdy), 32'd1);
        for (int i = 0; i < 4; i++) send(c1_a[i], c1_b[i], c1_p[i]);
        check("t1_vld_e0",    32'(st_vld), 32'd0);
        check("t1_rdy_drop",  32'(in_rdy), 32'd0);
        tick();
        check("t1_vld_e1",    32'(st_vld), 32'd0);
        wait_report("t1_report");
        check_stats("t1", 4, 0, 0, 19'd0, 0);
        finish_report("t1");
        check_stats("t1_hold", 4, 0, 0, 19'd0, 0);

        // 2: mixed errors
        pulse_start();
        for (int i = 0; i < 4; i++) send(c2_a[i], c2_b[i], c2_p[i]);
        wait_report("t2_report");
        check_stats("t2", 4, 2, 513, SED_NEG507, 510);
        finish_report("t2");

        // 3: toggled in_vld, back-pressured report, 5th sample not consumed
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                in_vld = 1'b0;
                tick();
            end
            in_a = c2_a[i];
            in_b = c2_b[i];
            in_p = c2_p[i];
            in_vld = 1'b1;
            check("t3_rdy_accum", 32'(in_rdy), 32'd1);
            tick();
        end
        in_a = 8'd1;
        in_b = 8'd1;
        in_p = 16'd0;
        in_vld = 1'b1;
        for (int n = 0; n < 10 && !st_vld; n++) begin
            check("t3_rdy_drain", 32'(in_rdy), 32'd0);
            tick();
        end
        check("t3_report", 32'(st_vld), 32'd1);
        for (int n = 0; n < 5; n++) begin
            check("t3_vld_hold", 32'(st_vld), 32'd1);
            check("t3_rdy_rep",  32'(in_rdy), 32'd0);
            check_stats("t3_stable", 4, 2, 513, SED_NEG507, 510);
            tick();
        end
        finish_report("t3");
        in_vld = 1'b0;
        check_stats("t3_final", 4, 2, 513, SED_NEG507, 510);

        // 4: clear mid-window, then a clean window
        pulse_start();
        send(c2_a[0], c2_b[0], c2_p[0]);
        send(c2_a[2], c2_b[2], c2_p[2]);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("t4_busy",   32'(busy),   32'd0);
        check("t4_in_rdy", 32'(in_rdy), 32'd0);
        for (int n = 0; n < 4; n++) begin
            check("t4_no_vld", 32'(st_vld), 32'd0);
            tick();
        end
        check_stats("t4_cleared", 0, 0, 0, 19'd0, 0);
        pulse_start();
        for (int i = 0; i < 4; i++) send(c1_a[i], c1_b[i], c1_p[i]);
        wait_report("t4_report");
        check_stats("t4", 4, 0, 0, 19'd0, 0);
        finish_report("t4");

        // 5: asynchronous reset in REPORT
        pulse_start();
        for (int i = 0; i < 4; i++) send(c2_a[i], c2_b[i], c2_p[i]);
        wait_report("t5_report");
        #3 rst_n = 1'b0;
        #1;
        check("t5_st_vld", 32'(st_vld), 32'd0);
        check("t5_busy",   32'(busy),   32'd0);
        check("t5_in_rdy", 32'(in_rdy), 32'd0);
        check_stats("t5", 0, 0, 0, 19'd0, 0);
        #2 rst_n = 1'b1;
        tick();

        // 6: start during ACCUM is ignored; start with clear in IDLE stays idle
        pulse_start();
        send(c2_a[2], c2_b[2], c2_p[2]);
        pulse_start();
        check("t6_busy",   32'(busy),   32'd1);
        check("t6_in_rdy", 32'(in_rdy), 32'd1);
        for (int i = 1; i < 4; i++) send(c1_a[i], c1_b[i], c1_p[i]);
        wait_report("t6_report");
        check_stats("t6", 4, 1, 3, 19'd3, 3);
        finish_report("t6");
        start = 1'b1;
        clear = 1'b1;
        tick();
        start = 1'b0;
        clear = 1'b0;
        check("t6_sc_busy",   32'(busy),   32'd0);
        check("t6_sc_in_rdy", 32'(in_rdy), 32'd0);
        tick();
        check("t6_sc_busy2",  32'(busy),   32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
